// File: rtl/buffer_reduce_engine.sv
// rtl/buffer_reduce_engine.sv - strided word-buffer reduction engine with optional result writeback
//
// Walks count words starting at base_addr, stepping stride bytes per element,
// and folds them into one value (sum, signed min, signed max or xor). The
// result can also be stored back to dst_addr before completion. The engine
// acts as a second requester on the data-memory port, with one read in flight.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start                launch request, accepted only while idle
//   base_addr, stride    byte address of element 0, byte step between elements
//   count, mode          element count, reduction mode (00 sum, 01 min, 10 max, 11 xor)
//   dst_addr             writeback byte address
//   busy, done           job in progress (through the done pulse), one-cycle completion pulse
//   result, overflow     final reduction, sticky carry-out in sum mode
//   mem_req/we/addr/wdata  memory request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  memory grant and read return
module buffer_reduce_engine #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter bit WRITEBACK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] MIN_INIT = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state;
    state_t state_next;
    state_t finish_state;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] stride_r;
    logic [ADDR_W-1:0] dst_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  idx;
    logic [1:0]        mode_r;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_init;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W:0]   sum_ext;
    logic              accept;
    logic              last_elem;

    // busy stays high during the done pulse, which coincides with the first
    // idle cycle; gating on it keeps a start in that cycle from being taken.
    assign accept       = (state == S_IDLE) && start && !busy;
    assign last_elem    = (idx + CNT_ONE) == cnt_r;
    assign finish_state = WRITEBACK ? S_WB : S_DONE;

    // Identity element of the requested operation.
    always_comb begin
        acc_init = '0;
        case (mode)
            MODE_MIN: acc_init = MIN_INIT;
            MODE_MAX: acc_init = MAX_INIT;
            default:  acc_init = '0;
        endcase
    end

    // Fold of the returning word into the accumulator.
    always_comb begin
        sum_ext  = {1'b0, acc} + {1'b0, mem_rdata};
        acc_next = acc ^ mem_rdata;
        case (mode_r)
            MODE_SUM: acc_next = sum_ext[DATA_W-1:0];
            MODE_MIN: acc_next = ($signed(mem_rdata) < $signed(acc)) ? mem_rdata : acc;
            MODE_MAX: acc_next = ($signed(mem_rdata) > $signed(acc)) ? mem_rdata : acc;
            default:  acc_next = acc ^ mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory-port outputs; the request fields come straight
    // from registered state so they hold steady while the grant is pending.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (count == '0) ? finish_state : S_REQ;
                end
            end
            S_REQ: begin
                mem_req  = 1'b1;
                mem_addr = ptr;
                if (mem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_next = last_elem ? finish_state : S_REQ;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_r;
                mem_wdata = acc;
                if (mem_gnt) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            acc      <= '0;
            idx      <= '0;
            ptr      <= '0;
            stride_r <= '0;
            dst_r    <= '0;
            cnt_r    <= '0;
            mode_r   <= '0;
        end else begin
            // done is registered off the DONE state, so result and done
            // become visible together one cycle after DONE.
            done <= (state == S_DONE);
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ptr      <= base_addr;
                        stride_r <= stride;
                        cnt_r    <= count;
                        mode_r   <= mode;
                        dst_r    <= dst_addr;
                        acc      <= acc_init;
                        overflow <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Read data is only consumed here, so a return that
                    // arrives after a reset lands in IDLE and is dropped.
                    if (mem_rvalid) begin
                        acc <= acc_next;
                        ptr <= ptr + stride_r;
                        idx <= idx + CNT_ONE;
                        if ((mode_r == MODE_SUM) && sum_ext[DATA_W]) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    result <= acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_reduce_engine.sv
// tb/tb_buffer_reduce_engine.sv - self-checking bench for buffer_reduce_engine
module tb_buffer_reduce_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [15:0] count;
    logic [1:0]  mode;
    logic [31:0] dst_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    buffer_reduce_engine #(
        .DATA_W(32), .ADDR_W(32), .CNT_W(16), .WRITEBACK(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .stride(stride), .count(count), .mode(mode), .dst_addr(dst_addr),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: sparse word store, random grant and read-return delays.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_addrs[$];
    int          wb_cnt = 0;
    logic [31:0] wb_addr = 32'h0;
    logic [31:0] wb_data = 32'h0;
    int          max_stall = 0;
    int          wcnt = 0;
    int          glat = 0;
    bit          pend = 1'b0;
    int          rcnt = 0;
    logic [31:0] paddr = 32'h0;
    int          stab_err = 0;
    bit          prev_req = 1'b0;
    bit          prev_gnt = 1'b0;
    bit          prev_we = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    assign mem_gnt = mem_req && (wcnt >= glat);

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        int rl;
        mem_rvalid <= 1'b0;
        if (pend) begin
            if (rcnt == 0) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= rd(paddr);
                pend       <= 1'b0;
            end else begin
                rcnt <= rcnt - 1;
            end
        end
        if (!mem_req) begin
            wcnt <= 0;
            glat <= int'($urandom_range(max_stall, 0));
        end else if (!mem_gnt) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (mem_we) begin
                wb_cnt++;
                wb_addr = mem_addr;
                wb_data = mem_wdata;
                mem[mem_addr] = mem_wdata;
            end else begin
                rd_addrs.push_back(mem_addr);
                rl = int'($urandom_range(max_stall, 0));
                if (rl == 0) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= rd(mem_addr);
                end else begin
                    pend  <= 1'b1;
                    rcnt  <= rl - 1;
                    paddr <= mem_addr;
                end
            end
        end
    end

    // A request waiting for its grant must keep address and direction.
    always @(negedge clk) begin
        if (prev_req && !prev_gnt && mem_req && (mem_addr !== prev_addr || mem_we !== prev_we)) begin
            stab_err++;
        end
        prev_req  = mem_req;
        prev_gnt  = mem_gnt;
        prev_we   = mem_we;
        prev_addr = mem_addr;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference reduction computed directly from the list of words.
    function automatic void model(input logic [1:0] m, input logic [31:0] w[$],
                                  output logic [31:0] r, output logic o);
        longint unsigned total;
        int best;
        total = 0;
        o = 1'b0;
        r = 32'h0;
        case (m)
            2'b00: begin
                foreach (w[i]) total += longint'(w[i]);
                r = total[31:0];
                o = (total >= 64'h1_0000_0000);
            end
            2'b01: begin
                best = 32'h7FFFFFFF;
                foreach (w[i]) if ($signed(w[i]) < best) best = $signed(w[i]);
                r = best;
            end
            2'b10: begin
                best = 32'h80000000;
                foreach (w[i]) if ($signed(w[i]) > best) best = $signed(w[i]);
                r = best;
            end
            default: begin
                foreach (w[i]) r = r ^ w[i];
            end
        endcase
    endfunction

    task automatic load(input logic [31:0] b, input logic [31:0] s, input logic [31:0] w[$]);
        foreach (w[i]) mem[b + s * 32'(i)] = w[i];
    endtask

    // Launch a job from #1 after an edge; returns cycles from start edge to
    // the done pulse (-1 on timeout). Optionally pokes start while busy.
    task automatic run_job(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n,
                           input logic [1:0] m, input logic [31:0] d, input bit poke,
                           output int cyc);
        rd_addrs.delete();
        wb_cnt = 0;
        base_addr = b; stride = s; count = n; mode = m; dst_addr = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (poke && cyc == 5) begin
                start = 1'b1; count = 16'd1; mode = 2'b11; base_addr = 32'h9000;
            end else if (poke && cyc == 6) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL job_timeout actual=%0d expected<3000", cyc);
            cyc = -1;
        end else begin
            @(posedge clk); #1;
            check("done_single_pulse", done, 1'b0);
        end
    endtask

    task automatic check_job(input string name, input logic [31:0] b, input logic [31:0] s,
                             input logic [31:0] w[$], input logic [1:0] m, input logic [31:0] d);
        logic [31:0] er;
        logic eo;
        int bad;
        model(m, w, er, eo);
        check({name, "_result"}, result, er);
        check({name, "_overflow"}, overflow, eo);
        bad = 0;
        if (rd_addrs.size() != w.size()) bad = 1000;
        else foreach (rd_addrs[i]) if (rd_addrs[i] !== b + s * 32'(i)) bad++;
        check({name, "_read_addrs"}, bad, 0);
        check({name, "_wb_count"}, wb_cnt, 1);
        check({name, "_wb_addr"}, wb_addr, d);
        check({name, "_wb_data"}, wb_data, er);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  mode;
        int          n;
        logic [31:0] w[4];
        logic [31:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic set_vec(input int k, input string nm, input logic [1:0] m, input int n,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input logic [31:0] er, input logic eo);
        vecs[k].name = nm; vecs[k].mode = m; vecs[k].n = n;
        vecs[k].w[0] = w0; vecs[k].w[1] = w1; vecs[k].w[2] = w2; vecs[k].w[3] = w3;
        vecs[k].exp_res = er; vecs[k].exp_ovf = eo;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] strides[4];
        logic [31:0] b;
        logic [31:0] s;
        logic [1:0]  m;
        logic [31:0] exp_addr[3];
        int cyc;
        int guard;
        int bad;

        set_vec(0, "tbl_min", 2'b01, 4, 32'd5, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFF9, 1'b0);
        set_vec(1, "tbl_max", 2'b10, 4, 32'd5, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFE, 32'h00000005, 1'b0);
        set_vec(2, "tbl_sum_ovf", 2'b00, 2, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'h00000001, 1'b1);
        set_vec(3, "tbl_xor", 2'b11, 3, 32'hF0, 32'h0F, 32'hFF, 32'h0, 32'h00000000, 1'b0);
        set_vec(4, "tbl_cnt0_max", 2'b10, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000, 1'b0);
        strides[0] = 32'd4; strides[1] = 32'd8; strides[2] = 32'hFFFFFFFC; strides[3] = 32'd12;

        reset = 1'b1; start = 1'b0; base_addr = '0; stride = '0; count = '0;
        mode = '0; dst_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // 128-word sum with zero-wait memory.
        w.delete();
        for (int i = 0; i < 128; i++) w.push_back(32'(i));
        load(32'h100, 32'd4, w);
        run_job(32'h100, 32'd4, 16'd128, 2'b00, 32'h300, 1'b0, cyc);
        check("sum128_latency", cyc, 258);
        check("sum128_const", result, 32'd8128);
        check_job("sum128", 32'h100, 32'd4, w, 2'b00, 32'h300);
        check("sum128_mem300", rd(32'h300), 32'd8128);

        // Table-driven vectors, zero-wait memory.
        for (int k = 0; k < 5; k++) begin
            w.delete();
            for (int i = 0; i < vecs[k].n; i++) w.push_back(vecs[k].w[i]);
            load(32'h1000, 32'd4, w);
            run_job(32'h1000, 32'd4, 16'(vecs[k].n), vecs[k].mode, 32'h2000, 1'b0, cyc);
            check({vecs[k].name, "_result"}, result, vecs[k].exp_res);
            check({vecs[k].name, "_overflow"}, overflow, vecs[k].exp_ovf);
            check({vecs[k].name, "_wb_data"}, wb_data, vecs[k].exp_res);
            check({vecs[k].name, "_reads"}, rd_addrs.size(), vecs[k].n);
            check({vecs[k].name, "_latency"}, cyc, 2 * vecs[k].n + 2);
        end

        // Address wrap with random stalls.
        max_stall = 5;
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        load(32'hFFFFFFF8, 32'd8, w);
        run_job(32'hFFFFFFF8, 32'd8, 16'd3, 2'b00, 32'h2100, 1'b0, cyc);
        exp_addr[0] = 32'hFFFFFFF8; exp_addr[1] = 32'h0; exp_addr[2] = 32'h8;
        bad = 0;
        if (rd_addrs.size() != 3) bad = 100;
        else for (int i = 0; i < 3; i++) if (rd_addrs[i] !== exp_addr[i]) bad++;
        check("wrap_addrs", bad, 0);
        check_job("wrap", 32'hFFFFFFF8, 32'd8, w, 2'b00, 32'h2100);

        // Randomised jobs with stalls.
        for (int it = 0; it < 8; it++) begin
            max_stall = int'($urandom_range(5, 0));
            w.delete();
            for (int i = 0; i < int'($urandom_range(20, 1)); i++) w.push_back($urandom);
            b = $urandom & 32'hFFFFFFFC;
            s = strides[$urandom_range(3, 0)];
            m = 2'($urandom_range(3, 0));
            load(b, s, w);
            run_job(b, s, 16'(w.size()), m, 32'h7000_0000 + 32'(it * 4), 1'b0, cyc);
            check_job($sformatf("rand%0d", it), b, s, w, m, 32'h7000_0000 + 32'(it * 4));
        end

        // Start offered in the done cycle is ignored, taken the cycle after.
        max_stall = 0;
        w.delete();
        w.push_back(32'h7);
        load(32'h5000, 32'd4, w);
        base_addr = 32'h5000; stride = 32'd4; count = 16'd1; mode = 2'b00; dst_addr = 32'h5100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!done && guard < 100) begin @(posedge clk); #1; guard++; end
        check("done_seen", done, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        check("start_in_done_ignored", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_done_taken", busy, 1'b1);
        guard = 0;
        while (!done && guard < 100) begin @(posedge clk); #1; guard++; end
        check("retake_result", result, 32'h7);
        @(posedge clk); #1;

        // Reset in the middle of a 128-element job.
        max_stall = 3;
        w.delete();
        for (int i = 0; i < 128; i++) w.push_back($urandom);
        load(32'h4000, 32'd4, w);
        rd_addrs.delete();
        base_addr = 32'h4000; stride = 32'd4; count = 16'd128; mode = 2'b00; dst_addr = 32'h4800;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (rd_addrs.size() < 40 && guard < 2000) begin @(posedge clk); #1; guard++; end
        check("reset_reached_elem40", rd_addrs.size() >= 40, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_result", result, 32'h0);
        check("midrst_overflow", overflow, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("late_rvalid_busy", busy, 1'b0);
        check("late_rvalid_result", result, 32'h0);
        run_job(32'h4000, 32'd4, 16'd128, 2'b00, 32'h4800, 1'b0, cyc);
        check_job("after_reset", 32'h4000, 32'd4, w, 2'b00, 32'h4800);

        // Start pulsed while busy is ignored.
        w.delete();
        for (int i = 0; i < 10; i++) w.push_back($urandom);
        load(32'h6000, 32'd4, w);
        run_job(32'h6000, 32'd4, 16'd10, 2'b10, 32'h6800, 1'b1, cyc);
        check_job("busy_start", 32'h6000, 32'd4, w, 2'b10, 32'h6800);
        repeat (5) @(posedge clk);
        #1;
        check("busy_start_no_second_job", busy, 1'b0);
        check("busy_start_no_extra_reads", rd_addrs.size(), 10);

        check("addr_stable_while_stalled", stab_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
